// File: rtl/mcpu_pkg.sv
// Shared definitions for the mcpu fetch path: default widths, fetch FSM encoding, halt opcode.
// HALTED exists only when MCPU_FETCH_HALT_EN is defined.
package mcpu_pkg;

  localparam int WORD_SIZE_DEF  = 8;
  localparam int ADDR_WIDTH_DEF = 8;

  localparam logic [7:0] HALT_OPCODE = 8'hFF;

`ifdef MCPU_FETCH_HALT_EN
  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    ISSUE     = 2'd2,
    HALTED    = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    ISSUE     = 2'd2
  } fetch_state_e;
`endif

endpackage

// File: rtl/mcpu_pc_counter.sv
// Program counter: reset value, branch load, and modulo-2^ADDR_WIDTH increment.
// A load wins over an increment; with neither, the pc holds.
module mcpu_pc_counter
  import mcpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mcpu_fetch_unit.sv
// Two-byte instruction fetch unit: reads opcode and operand through the instruction port,
// then presents them to decode. Optional halt support under MCPU_FETCH_HALT_EN.
module mcpu_fetch_unit
  import mcpu_pkg::*;
#(
  parameter int                    WORD_SIZE  = WORD_SIZE_DEF,
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] instraddr,
  input  logic [WORD_SIZE-1:0]  instrrd,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [WORD_SIZE-1:0]  opcode,
  output logic [WORD_SIZE-1:0]  operand,
  output logic [ADDR_WIDTH-1:0] instr_pc,
`ifdef MCPU_FETCH_HALT_EN
  output logic                  halted,
`endif
  output fetch_state_e          fsm_state
);

  // Handshake: instr_valid is high only in ISSUE and holds opcode/operand/instr_pc
  // stable; a transfer happens on any edge where instr_valid && instr_ready.
  // instr_ready outside ISSUE has no effect.

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_load;
  logic                  pc_inc;
  logic                  handshake;

`ifdef MCPU_FETCH_HALT_EN
  assign pc_load = branch_en && (state != HALTED);
`else
  assign pc_load = branch_en;
`endif
  assign pc_inc    = (state == FETCH_OP) || (state == FETCH_ARG);
  assign handshake = instr_valid && instr_ready;
  assign instraddr = pc;
  assign fsm_state = state;

  mcpu_pc_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pc_load),
    .load_addr (branch_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH_OP;
      opcode      <= '0;
      operand     <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
`ifdef MCPU_FETCH_HALT_EN
      halted      <= 1'b0;
`endif
    end else if (pc_load) begin
      // Redirect: any partly fetched bytes are simply never issued.
      state       <= FETCH_OP;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH_OP: begin
          opcode   <= instrrd;
          instr_pc <= pc;
          state    <= FETCH_ARG;
        end
        FETCH_ARG: begin
          operand     <= instrrd;
          instr_valid <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (handshake) begin
            instr_valid <= 1'b0;
`ifdef MCPU_FETCH_HALT_EN
            if (opcode == WORD_SIZE'(HALT_OPCODE)) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              state  <= FETCH_OP;
            end
`else
            state <= FETCH_OP;
`endif
          end
        end
        default: begin
          // HALTED (when present) is only left through reset.
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_fetch_unit.sv
// Directed bench for mcpu_fetch_unit: fetch timing, stall, redirects, pc wrap, halt, reset.
// Build with MCPU_FETCH_HALT_EN defined to exercise the halt path.
module tb_mcpu_fetch_unit;
  import mcpu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] instraddr;
  logic [7:0] instrrd;
  logic       branch_en;
  logic [7:0] branch_addr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic [7:0] instr_pc;
`ifdef MCPU_FETCH_HALT_EN
  logic       halted;
`endif
  fetch_state_e fsm_state;

  logic [7:0] mem [0:255];
  int total;
  int bad;

  assign instrrd = mem[instraddr];

  mcpu_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instraddr   (instraddr),
    .instrrd     (instrrd),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .operand     (operand),
    .instr_pc    (instr_pc),
`ifdef MCPU_FETCH_HALT_EN
    .halted      (halted),
`endif
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n       = 1'b0;
    branch_en   = 1'b0;
    branch_addr = 8'h00;
    instr_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34;
    mem[8'h02] = 8'h56; mem[8'h03] = 8'h78;
    mem[8'h04] = 8'h66; mem[8'h05] = 8'h77;
    mem[8'h10] = 8'hFF; mem[8'h11] = 8'h00;
    mem[8'h12] = 8'h9A; mem[8'h13] = 8'hBC;
    mem[8'h40] = 8'hA1; mem[8'h41] = 8'hB2;
    mem[8'hFF] = 8'hC3;
  end

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++; if (fsm_state !== FETCH_OP) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", fsm_state, FETCH_OP); end
    total++; if (instraddr !== 8'h00) begin bad++; $display("FAIL rst_pc got=%h exp=00", instraddr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    total++; if ({opcode, operand, instr_pc} !== 24'h000000) begin bad++; $display("FAIL rst_regs got=%h exp=000000", {opcode, operand, instr_pc}); end
`ifdef MCPU_FETCH_HALT_EN
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
`endif
    rst_n       = 1'b1;
    instr_ready = 1'b1;
  endtask

  task automatic test_first_fetch();
    @(negedge clk);
    total++; if (fsm_state !== FETCH_ARG) begin bad++; $display("FAIL ff_state1 got=%0d exp=%0d", fsm_state, FETCH_ARG); end
    total++; if ({instr_valid, opcode, instr_pc, instraddr} !== {1'b0, 8'h12, 8'h00, 8'h01}) begin bad++; $display("FAIL ff_c1 got=%h exp=%h", {instr_valid, opcode, instr_pc, instraddr}, {1'b0, 8'h12, 8'h00, 8'h01}); end
    @(negedge clk);
    total++; if (fsm_state !== ISSUE) begin bad++; $display("FAIL ff_state2 got=%0d exp=%0d", fsm_state, ISSUE); end
    total++; if ({instr_valid, opcode, operand, instr_pc, instraddr} !== {1'b1, 8'h12, 8'h34, 8'h00, 8'h02}) begin bad++; $display("FAIL ff_issue got=%h exp=%h", {instr_valid, opcode, operand, instr_pc, instraddr}, {1'b1, 8'h12, 8'h34, 8'h00, 8'h02}); end
    instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if ({instr_valid, opcode, operand, instr_pc, instraddr} !== {1'b1, 8'h12, 8'h34, 8'h00, 8'h02}) begin bad++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, {instr_valid, opcode, operand, instr_pc, instraddr}, {1'b1, 8'h12, 8'h34, 8'h00, 8'h02}); end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    total++; if (fsm_state !== FETCH_OP || instr_valid !== 1'b0 || instraddr !== 8'h02) begin bad++; $display("FAIL stall_accept got st=%0d v=%b pc=%h exp st=0 v=0 pc=02", fsm_state, instr_valid, instraddr); end
    @(negedge clk);
    total++; if ({opcode, instr_pc} !== {8'h56, 8'h02}) begin bad++; $display("FAIL stall_next_op got=%h exp=5602", {opcode, instr_pc}); end
    @(negedge clk);
    total++; if ({instr_valid, operand, instraddr} !== {1'b1, 8'h78, 8'h04}) begin bad++; $display("FAIL stall_next_issue got=%h exp=%h", {instr_valid, operand, instraddr}, {1'b1, 8'h78, 8'h04}); end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    total++; if (fsm_state !== FETCH_OP || instraddr !== 8'h04) begin bad++; $display("FAIL stall_done got st=%0d pc=%h exp st=0 pc=04", fsm_state, instraddr); end
  endtask

  task automatic test_branch_fetch_arg();
    @(negedge clk);
    total++; if (fsm_state !== FETCH_ARG || {opcode, instr_pc} !== {8'h66, 8'h04}) begin bad++; $display("FAIL br_pre got st=%0d %h exp st=1 6604", fsm_state, {opcode, instr_pc}); end
    branch_en   = 1'b1;
    branch_addr = 8'h40;
    @(negedge clk);
    branch_en = 1'b0;
    total++; if (fsm_state !== FETCH_OP || instr_valid !== 1'b0 || instraddr !== 8'h40) begin bad++; $display("FAIL br_redirect got st=%0d v=%b pc=%h exp st=0 v=0 pc=40", fsm_state, instr_valid, instraddr); end
    @(negedge clk);
    total++; if ({instr_valid, opcode, instr_pc} !== {1'b0, 8'hA1, 8'h40}) begin bad++; $display("FAIL br_op got=%h exp=%h", {instr_valid, opcode, instr_pc}, {1'b0, 8'hA1, 8'h40}); end
    @(negedge clk);
    total++; if ({instr_valid, operand, instr_pc} !== {1'b1, 8'hB2, 8'h40}) begin bad++; $display("FAIL br_issue got=%h exp=%h", {instr_valid, operand, instr_pc}, {1'b1, 8'hB2, 8'h40}); end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    total++; if (instraddr !== 8'h42) begin bad++; $display("FAIL br_after got=%h exp=42", instraddr); end
  endtask

  task automatic test_pc_wrap();
    branch_en   = 1'b1;
    branch_addr = 8'hFF;
    @(negedge clk);
    branch_en = 1'b0;
    total++; if (fsm_state !== FETCH_OP || instraddr !== 8'hFF) begin bad++; $display("FAIL wrap_load got st=%0d pc=%h exp st=0 pc=ff", fsm_state, instraddr); end
    @(negedge clk);
    total++; if ({opcode, instr_pc, instraddr} !== {8'hC3, 8'hFF, 8'h00}) begin bad++; $display("FAIL wrap_op got=%h exp=c3ff00", {opcode, instr_pc, instraddr}); end
    @(negedge clk);
    total++; if ({instr_valid, operand, instraddr} !== {1'b1, 8'h12, 8'h01}) begin bad++; $display("FAIL wrap_issue got=%h exp=%h", {instr_valid, operand, instraddr}, {1'b1, 8'h12, 8'h01}); end
  endtask

  task automatic test_branch_handshake();
    instr_ready = 1'b1;
    branch_en   = 1'b1;
    branch_addr = 8'h10;
    @(negedge clk);
    instr_ready = 1'b0;
    branch_en   = 1'b0;
    total++; if (fsm_state !== FETCH_OP || instr_valid !== 1'b0 || instraddr !== 8'h10) begin bad++; $display("FAIL bh_redirect got st=%0d v=%b pc=%h exp st=0 v=0 pc=10", fsm_state, instr_valid, instraddr); end
    @(negedge clk);
    total++; if ({opcode, instr_pc} !== {8'hFF, 8'h10}) begin bad++; $display("FAIL bh_op got=%h exp=ff10", {opcode, instr_pc}); end
    @(negedge clk);
    total++; if ({instr_valid, operand, instraddr} !== {1'b1, 8'h00, 8'h12}) begin bad++; $display("FAIL bh_issue got=%h exp=%h", {instr_valid, operand, instraddr}, {1'b1, 8'h00, 8'h12}); end
  endtask

`ifdef MCPU_FETCH_HALT_EN
  task automatic test_halt();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    total++; if (fsm_state !== HALTED || halted !== 1'b1 || instr_valid !== 1'b0 || instraddr !== 8'h12) begin bad++; $display("FAIL halt_enter got st=%0d h=%b v=%b pc=%h exp st=3 h=1 v=0 pc=12", fsm_state, halted, instr_valid, instraddr); end
    branch_en   = 1'b1;
    branch_addr = 8'h40;
    @(negedge clk);
    branch_en = 1'b0;
    total++; if (fsm_state !== HALTED || halted !== 1'b1 || instraddr !== 8'h12) begin bad++; $display("FAIL halt_branch got st=%0d h=%b pc=%h exp st=3 h=1 pc=12", fsm_state, halted, instraddr); end
    instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    instr_ready = 1'b0;
    total++; if (instr_valid !== 1'b0 || instraddr !== 8'h12 || halted !== 1'b1) begin bad++; $display("FAIL halt_frozen got v=%b pc=%h h=%b exp v=0 pc=12 h=1", instr_valid, instraddr, halted); end
    rst_n = 1'b0;
    #1;
    total++; if (fsm_state !== FETCH_OP || halted !== 1'b0 || instraddr !== 8'h00 || opcode !== 8'h00) begin bad++; $display("FAIL halt_reset got st=%0d h=%b pc=%h op=%h exp st=0 h=0 pc=00 op=00", fsm_state, halted, instraddr, opcode); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({opcode, instr_pc} !== {8'h12, 8'h00}) begin bad++; $display("FAIL halt_restart got=%h exp=1200", {opcode, instr_pc}); end
  endtask
`else
  task automatic test_ff_ordinary();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    total++; if (fsm_state !== FETCH_OP || instr_valid !== 1'b0 || instraddr !== 8'h12) begin bad++; $display("FAIL ff_accept got st=%0d v=%b pc=%h exp st=0 v=0 pc=12", fsm_state, instr_valid, instraddr); end
    @(negedge clk);
    total++; if ({opcode, instr_pc} !== {8'h9A, 8'h12}) begin bad++; $display("FAIL ff_next_op got=%h exp=9a12", {opcode, instr_pc}); end
    @(negedge clk);
    total++; if ({instr_valid, operand} !== {1'b1, 8'hBC}) begin bad++; $display("FAIL ff_next_issue got=%h exp=%h", {instr_valid, operand}, {1'b1, 8'hBC}); end
  endtask
`endif

  task automatic test_reset_mid_fetch();
    branch_en   = 1'b1;
    branch_addr = 8'h02;
    @(negedge clk);
    branch_en = 1'b0;
    @(negedge clk);
    total++; if (fsm_state !== FETCH_ARG || {opcode, instr_pc} !== {8'h56, 8'h02}) begin bad++; $display("FAIL mid_pre got st=%0d %h exp st=1 5602", fsm_state, {opcode, instr_pc}); end
    rst_n = 1'b0;
    #1;
    total++; if (fsm_state !== FETCH_OP || {instr_valid, opcode, instr_pc, instraddr} !== {1'b0, 8'h00, 8'h00, 8'h00}) begin bad++; $display("FAIL mid_async got st=%0d %h exp st=0 0000000", fsm_state, {instr_valid, opcode, instr_pc, instraddr}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({opcode, instr_pc, instraddr} !== {8'h12, 8'h00, 8'h01}) begin bad++; $display("FAIL mid_restart got=%h exp=120001", {opcode, instr_pc, instraddr}); end
    @(negedge clk);
    total++; if ({instr_valid, operand} !== {1'b1, 8'h34}) begin bad++; $display("FAIL mid_issue got=%h exp=%h", {instr_valid, operand}, {1'b1, 8'h34}); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_branch_fetch_arg();
    test_pc_wrap();
    test_branch_handshake();
`ifdef MCPU_FETCH_HALT_EN
    test_halt();
`else
    test_ff_ordinary();
`endif
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcpu_fetch_unit.md
MCPU_FETCH_UNIT -- requirements
Module: mcpu_fetch_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8: width of one memory word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: width of an instruction address.
REQ-003 SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port instraddr, output, ADDR_WIDTH bits: instruction-port address to the RAM controller.
REQ-008 SHALL have port instrrd, input, WORD_SIZE bits: combinational instruction-port read data from the RAM controller.
REQ-009 SHALL have port branch_en, input, 1 bit: one-cycle redirect request.
REQ-010 SHALL have port branch_addr, input, ADDR_WIDTH bits: redirect target.
REQ-011 SHALL have port instr_valid, output, 1 bit: an instruction is presented to decode.
REQ-012 SHALL have port instr_ready, input, 1 bit: decode accepts the instruction.
REQ-013 SHALL have port opcode, output, WORD_SIZE bits: first instruction byte.
REQ-014 SHALL have port operand, output, WORD_SIZE bits: second instruction byte.
REQ-015 SHALL have port instr_pc, output, ADDR_WIDTH bits: address of the opcode byte.

Function
REQ-016 SHALL hold a registered pc and drive instraddr = pc combinationally.
REQ-017 SHALL implement FSM states FETCH_OP, FETCH_ARG, ISSUE (plus HALTED, see REQ-030).
REQ-018 FETCH_OP SHALL, at the clock edge, latch instrrd into opcode, latch pc into instr_pc, increment pc, and move to FETCH_ARG.
REQ-019 FETCH_ARG SHALL, at the clock edge, latch instrrd into operand, increment pc, and move to ISSUE.
REQ-020 ISSUE SHALL assert instr_valid, keeping opcode, operand and instr_pc stable until the handshake completes.
REQ-021 ISSUE SHALL move to FETCH_OP on the edge where instr_valid and instr_ready are both 1, and SHALL otherwise stay in ISSUE.
REQ-022 Issue latency SHALL be 2 cycles from entering FETCH_OP to instr_valid; peak throughput SHALL be 1 instruction per 3 cycles.
REQ-023 instr_valid SHALL be 0 in every state other than ISSUE.
REQ-024 pc arithmetic SHALL be modulo 2^ADDR_WIDTH, so 0xFF+1 = 0x00 at defaults.
REQ-025 When branch_en = 1 in any non-HALTED state, the next edge SHALL load pc <= branch_addr, enter FETCH_OP and discard any partly fetched bytes.
REQ-026 branch_en SHALL take priority over every other transition.
REQ-027 When branch_en coincides with a completed ISSUE handshake, the instruction SHALL count as consumed and the redirect SHALL also take effect.
REQ-028 The unit SHALL never write memory and SHALL tolerate instr_ready being asserted outside ISSUE by ignoring it.

Reset
REQ-029 On rst_n = 0, the unit SHALL immediately set: state FETCH_OP; pc = RESET_PC; opcode, operand and instr_pc = 0; instr_valid = 0; halted = 0.
REQ-029a A reset in mid-fetch SHALL abandon the fetch, and fetching SHALL restart at RESET_PC on the first edge after rst_n rises.

Configuration
REQ-030 Macro MCPU_FETCH_HALT_EN defined: add output port halted (1 bit).
REQ-030a With MCPU_FETCH_HALT_EN defined: when an instruction with opcode == HALT_OPCODE (0xFF) is accepted in ISSUE, the FSM SHALL enter HALTED.
REQ-030b In HALTED, pc SHALL be frozen, instr_valid SHALL be 0, halted SHALL be 1, branch_en SHALL be ignored, and only reset SHALL exit the state.
REQ-031 Macro undefined: the halted port and the HALTED state SHALL be absent, and 0xFF SHALL be treated as an ordinary opcode.

Structure
REQ-032 Shared package mcpu_pkg SHALL hold WORD_SIZE/ADDR_WIDTH defaults, the fetch state encoding, and HALT_OPCODE.
REQ-033 The unit SHALL contain one sub-module, mcpu_pc_counter, covering pc register, increment, branch load and reset value.

Verification
REQ-034 Reset, then RAM[0..1] = 0x12, 0x34 with instr_ready = 1: instr_valid rises in the 3rd cycle with opcode 0x12, operand 0x34, instr_pc 0x00.
REQ-035 Hold instr_ready = 0 for 5 cycles in ISSUE: outputs stay stable and pc stays 0x02; ready = 1 then gives the next fetch from 0x02.
REQ-036 branch_en with branch_addr = 0x40 during FETCH_ARG: no instr_valid for the discarded instruction; the next instr_pc is 0x40.
REQ-037 Start pc = 0xFF via branch: opcode comes from 0xFF, operand from 0x00, and pc becomes 0x01.
REQ-038 With MCPU_FETCH_HALT_EN defined and opcode 0xFF accepted: halted = 1 and pc is frozen; a branch_en pulse has no effect; an rst_n pulse restarts at RESET_PC.
